// File: rtl/opqueue_issue_ctrl.sv
// Operand-queue issue controller: command FIFO, issue FSM and
// credit gating of VRF read grants for one operand queue.
module opqueue_issue_ctrl #(
  parameter int unsigned BufferDepth = 5,
  parameter int unsigned CmdDepth    = 4,
  parameter int unsigned CntWidth    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [CntWidth-1:0] cmd_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  output logic [CntWidth-1:0] opq_cmd_o,
  output logic                opq_cmd_valid_o,
  input  logic                req_i,
  output logic                gnt_o,
  input  logic                consume_i,
  output logic                done_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int unsigned CrW  = $clog2(BufferDepth + 1);
  localparam int unsigned PtrW = (CmdDepth > 1) ? $clog2(CmdDepth) : 1;
  localparam int unsigned FcW  = $clog2(CmdDepth + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  state_e              state_q;
  logic [CntWidth-1:0] mem_q [CmdDepth];
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [FcW-1:0]      fcnt_q;
  logic [CrW-1:0]      credits_q;
  logic [CntWidth-1:0] rem_issue_q, rem_cons_q;
  logic [CntWidth-1:0] rem_issue_d, rem_cons_d;
  logic [CntWidth-1:0] opq_cmd_q;
  logic                opq_cmd_valid_q;
  logic                done_q;
  logic                err_q;

  logic                fifo_full;
  logic                push, pop;
  logic                cons_ok;
  logic                gnt;
  logic [CntWidth-1:0] head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(CmdDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full   = (fcnt_q == FcW'(CmdDepth));
  assign cmd_ready_o = !fifo_full;
  assign push        = cmd_valid_i && !fifo_full && !flush_i;
  // Only entries already registered are visible, so a push is never popped
  // in its own cycle.
  assign pop         = (state_q == IDLE) && (fcnt_q != '0) && !flush_i;
  assign head        = mem_q[rptr_q];
  assign cons_ok     = consume_i && (rem_cons_q != '0);
  assign gnt         = (state_q == ISSUE) && req_i && (credits_q != '0)
                       && (rem_issue_q != '0) && !flush_i;
  assign rem_issue_d = rem_issue_q - CntWidth'(gnt);
  assign rem_cons_d  = rem_cons_q - CntWidth'(cons_ok);

  assign gnt_o           = gnt;
  assign opq_cmd_o       = opq_cmd_q;
  assign opq_cmd_valid_o = opq_cmd_valid_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign busy_o          = (state_q != IDLE) || (fcnt_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      wptr_q          <= '0;
      rptr_q          <= '0;
      fcnt_q          <= '0;
      credits_q       <= CrW'(BufferDepth);
      rem_issue_q     <= '0;
      rem_cons_q      <= '0;
      opq_cmd_q       <= '0;
      opq_cmd_valid_q <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else if (flush_i) begin
      state_q         <= IDLE;
      wptr_q          <= '0;
      rptr_q          <= '0;
      fcnt_q          <= '0;
      credits_q       <= CrW'(BufferDepth);
      rem_issue_q     <= '0;
      rem_cons_q      <= '0;
      opq_cmd_valid_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      opq_cmd_valid_q <= 1'b0;
      done_q          <= 1'b0;
      if (consume_i && !cons_ok) err_q <= 1'b1;
      if (push) begin
        mem_q[wptr_q] <= cmd_i;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      fcnt_q      <= fcnt_q + FcW'(push) - FcW'(pop);
      credits_q   <= credits_q + CrW'(cons_ok) - CrW'(gnt);
      rem_issue_q <= rem_issue_d;
      rem_cons_q  <= rem_cons_d;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            if (head != '0) begin
              rem_issue_q     <= head;
              rem_cons_q      <= head;
              opq_cmd_q       <= head;
              opq_cmd_valid_q <= 1'b1;
              state_q         <= ISSUE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (rem_issue_d == '0) state_q <= DRAIN;
        end
        DRAIN: begin
          if (rem_cons_d == '0) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opqueue_issue_ctrl.sv
// Scoreboard bench for opqueue_issue_ctrl: directed scenarios plus
// random traffic checked against a transaction-level model.
module tb_opqueue_issue_ctrl;

  localparam int BD = 5;
  localparam int CD = 4;

  logic        clk;
  logic        rst_i, flush_i;
  logic [15:0] cmd_i;
  logic        cmd_valid_i, cmd_ready_o;
  logic [15:0] opq_cmd_o;
  logic        opq_cmd_valid_o;
  logic        req_i, gnt_o, consume_i;
  logic        done_o, busy_o, err_o;

  opqueue_issue_ctrl #(
    .BufferDepth(BD),
    .CmdDepth   (CD),
    .CntWidth   (16)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .cmd_i          (cmd_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .opq_cmd_o      (opq_cmd_o),
    .opq_cmd_valid_o(opq_cmd_valid_o),
    .req_i          (req_i),
    .gnt_o          (gnt_o),
    .consume_i      (consume_i),
    .done_o         (done_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit chk;
    bit gnt;
    bit opqv;
    bit done;
    bit busy;
    bit err;
    bit rdy;
  } exp_t;

  exp_t exp_q[$];
  int   exp_cmd[$];
  int   tests = 0;
  int   fails = 0;

  // Model: pending command list plus issued/consumed tallies of the
  // active command; credits are BD minus elements in flight.
  int pend[$];
  bit act;
  int cur_n, issued, consumed;
  bit m_opqv, m_done, m_err;

  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", n, a, e, $time);
    end
  endtask

  function automatic bit can_consume();
    return act && (issued > consumed);
  endfunction

  task automatic clear_model(input bit keep_err);
    pend.delete();
    act      = 0;
    cur_n    = 0;
    issued   = 0;
    consumed = 0;
    m_opqv   = 0;
    m_done   = 0;
    if (!keep_err) m_err = 0;
  endtask

  task automatic cyc(input bit r, input bit f, input bit v, input int c,
                     input bit rq, input bit cs, input bit ck = 1);
    exp_t e;
    bit   push_ok, ok, was_drain;
    int   n;
    @(posedge clk);
    #1;
    rst_i       = r;
    flush_i     = f;
    cmd_valid_i = v;
    cmd_i       = 16'(c);
    req_i       = rq;
    consume_i   = cs;
    e.chk  = ck;
    e.gnt  = !f && act && (issued < cur_n) && rq
             && ((BD - (issued - consumed)) > 0);
    e.opqv = m_opqv;
    e.done = m_done;
    e.busy = act || (pend.size() != 0);
    e.err  = m_err;
    e.rdy  = pend.size() < CD;
    exp_q.push_back(e);
    if (r) begin
      clear_model(0);
    end else if (f) begin
      clear_model(1);
    end else begin
      push_ok   = v && (pend.size() < CD);
      ok        = cs && act && (consumed < cur_n);
      was_drain = act && (issued == cur_n);
      m_opqv    = 0;
      m_done    = 0;
      if (cs && !ok) m_err = 1;
      if (ok) consumed++;
      if (e.gnt) issued++;
      if (was_drain && consumed == cur_n) begin
        act    = 0;
        m_done = 1;
      end else if (!act && pend.size() != 0) begin
        n = pend.pop_front();
        if (n == 0) begin
          m_done = 1;
        end else begin
          act      = 1;
          cur_n    = n;
          issued   = 0;
          consumed = 0;
          m_opqv   = 1;
          exp_cmd.push_back(n);
        end
      end
      if (push_ok) pend.push_back(c);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_auto(input int k, input int preq, input int pcons);
    bit cs, rq;
    repeat (k) begin
      cs = can_consume() && ($urandom_range(99) < pcons);
      rq = $urandom_range(99) < preq;
      cyc(0, 0, 0, 0, rq, cs);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          chk("gnt", int'(gnt_o), int'(e.gnt));
          chk("opq_valid", int'(opq_cmd_valid_o), int'(e.opqv));
          chk("done", int'(done_o), int'(e.done));
          chk("busy", int'(busy_o), int'(e.busy));
          chk("err", int'(err_o), int'(e.err));
          chk("cmd_ready", int'(cmd_ready_o), int'(e.rdy));
        end
      end
      if (opq_cmd_valid_o === 1'b1 && exp_cmd.size() != 0)
        chk("opq_cmd", int'(opq_cmd_o), exp_cmd.pop_front());
    end
  end

  initial begin : driver
    bit v, f, r, rq, cs;
    int c;
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    cmd_i       = '0;
    cmd_valid_i = 1'b0;
    req_i       = 1'b0;
    consume_i   = 1'b0;
    m_err       = 0;
    clear_model(0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(2);
    // cmd 3, req held, then three consumes
    cyc(0, 0, 1, 3, 1, 0);
    repeat (6) cyc(0, 0, 0, 0, 1, 0);
    repeat (3) begin
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0);
    end
    idle(3);
    // cmd 8 exceeds credits
    cyc(0, 0, 1, 8, 1, 0);
    repeat (10) cyc(0, 0, 0, 0, 1, 0);
    run_auto(30, 100, 100);
    idle(2);
    // cmd 10 with grant and consume every cycle
    cyc(0, 0, 1, 10, 1, 0);
    run_auto(30, 100, 100);
    idle(2);
    // fill the FIFO behind a stalled command, then an overflow attempt
    cyc(0, 0, 1, 2, 0, 0);
    cyc(0, 0, 1, 3, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 2, 0, 0);
    cyc(0, 0, 1, 7, 0, 0);
    run_auto(60, 100, 100);
    idle(2);
    // flush after two grants of cmd 6
    cyc(0, 0, 1, 6, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 1, 1, 9, 1, 0);
    cyc(0, 0, 1, 1, 1, 0);
    run_auto(10, 100, 100);
    idle(2);
    // stray consume sets sticky err; flush keeps it, reset clears it
    cyc(0, 0, 0, 0, 0, 1);
    idle(2);
    cyc(0, 1, 0, 0, 0, 0);
    idle(2);
    cyc(1, 0, 0, 0, 0, 0);
    idle(2);
    // random traffic
    repeat (3000) begin
      r  = $urandom_range(499) == 0;
      f  = $urandom_range(59) == 0;
      v  = $urandom_range(2) == 0;
      c  = $urandom_range(7);
      rq = $urandom_range(99) < 70;
      if (act) cs = can_consume() && ($urandom_range(99) < 60);
      else cs = $urandom_range(199) == 0;
      cyc(r, f, v, c, rq, cs);
    end
    idle(3);
    begin : wait_drain
      int k;
      for (k = 0; k < 100; k++) begin
        if (exp_q.size() == 0) break;
        @(negedge clk);
      end
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL drain_timeout left=%0d", exp_q.size());
      end
    end
    @(negedge clk);
    chk("cmd_queue_empty", exp_cmd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
